xadc_drp_responder: RTL and testbench

- Synthesizable DRP responder (slave) that emulates the XADC dynamic reconfiguration port, the other end of the DRP read loop the joystick direction logic runs.
- Provides a conversion sequencer that alternates VAUX6/VAUX7 and pulses EOC, plus a small DRP register file holding the results.
- Substitutes for the XADC IP when no joystick is fitted (channel values come from switches) and gives the DRP reader a deterministic, cycle-exact partner.

---
 rtl/xadc_pkg.sv | 25 ++
 rtl/xadc_drp_responder_conv_seq.sv | 72 +++++++
 rtl/xadc_drp_responder.sv | 160 ++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xadc_pkg
// Brief    : Shared constants and DRP state type for the XADC DRP responder.
// Revision : 1.0 - initial release
// ============================================================================
package xadc_pkg;

    localparam logic [6:0] ADDR_VAUX6 = 7'h16;
    localparam logic [6:0] ADDR_VAUX7 = 7'h17;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    localparam logic [4:0] CH_VAUX6 = 5'd22;
    localparam logic [4:0] CH_VAUX7 = 5'd23;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_RESP = 2'd2
    } drp_state_t;

endpackage
`default_nettype wire

// File: rtl/xadc_drp_responder_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : xadc_conv_seq
// Brief    : Free-running conversion sequencer alternating VAUX6/VAUX7.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_conv_seq
    import xadc_pkg::*;
#(
    parameter int CONV_CYCLES = 26
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_eoc,
    output logic       o_eos,
    output logic [4:0] o_channel,
    output logic       o_busy,
    output logic       o_wr_aux6,
    output logic       o_wr_aux7
);

    localparam int             CW       = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CONV_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ch7_q, ch7_d;
    logic          eoc_q, eoc_d;
    logic          eos_q, eos_d;
    logic [4:0]    channel_q, channel_d;
    logic          busy_q, busy_d;
    logic          w_term;

    assign w_term = (cnt_q == CNT_LAST);

    // Result strobes fire on the terminal count so the result lands with EOC.
    assign o_wr_aux6 = w_term & ~ch7_q;
    assign o_wr_aux7 = w_term &  ch7_q;

    always_comb begin
        cnt_d     = w_term ? '0 : cnt_q + CW'(1);
        ch7_d     = ch7_q ^ w_term;
        eoc_d     = w_term;
        eos_d     = w_term & ch7_q;
        channel_d = w_term ? (ch7_q ? CH_VAUX7 : CH_VAUX6) : channel_q;
        busy_d    = ~w_term;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            ch7_q     <= 1'b0;
            eoc_q     <= 1'b0;
            eos_q     <= 1'b0;
            channel_q <= 5'd0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ch7_q     <= ch7_d;
            eoc_q     <= eoc_d;
            eos_q     <= eos_d;
            channel_q <= channel_d;
            busy_q    <= busy_d;
        end
    end

    assign o_eoc     = eoc_q;
    assign o_eos     = eos_q;
    assign o_channel = channel_q;
    assign o_busy    = busy_q;

endmodule
`default_nettype wire

// File: rtl/xadc_drp_responder.sv
`default_nettype none
// ============================================================================
// Module   : xadc_drp_responder
// Brief    : XADC DRP slave emulation: register file, DRP FSM, sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_responder
    import xadc_pkg::*;
#(
    parameter int CONV_CYCLES  = 26,
    parameter int DRDY_LATENCY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_den,
    input  logic        i_dwe,
    input  logic [6:0]  i_daddr,
    input  logic [15:0] i_di,
    output logic        o_drdy,
    output logic [15:0] o_do,
    output logic        o_eoc,
    output logic        o_eos,
    output logic [4:0]  o_channel,
    output logic        o_busy,
    output logic        o_err,
    input  logic [11:0] i_aux6_val,
    input  logic [11:0] i_aux7_val
);

    localparam int LW = (DRDY_LATENCY > 1) ? $clog2(DRDY_LATENCY + 1) : 1;

    drp_state_t    state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [6:0]    addr_q, addr_d;
    logic          dwe_q, dwe_d;
    logic [15:0]   di_q, di_d;
    logic          drdy_q, drdy_d;
    logic [15:0]   do_q, do_d;
    logic          err_q, err_d;
    logic [15:0]   res6_q, res6_d, res7_q, res7_d;
    logic [15:0]   cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic [15:0]   w_rd_data;
    logic          w_wr_aux6, w_wr_aux7;

    xadc_conv_seq #(
        .CONV_CYCLES (CONV_CYCLES)
    ) u_seq (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .o_eoc     (o_eoc),
        .o_eos     (o_eos),
        .o_channel (o_channel),
        .o_busy    (o_busy),
        .o_wr_aux6 (w_wr_aux6),
        .o_wr_aux7 (w_wr_aux7)
    );

    always_comb begin
        case (addr_q)
            ADDR_VAUX6: w_rd_data = res6_q;
            ADDR_VAUX7: w_rd_data = res7_q;
            ADDR_CFG0:  w_rd_data = cfg0_q;
            ADDR_CFG1:  w_rd_data = cfg1_q;
            ADDR_CFG2:  w_rd_data = cfg2_q;
            default:    w_rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        dwe_d   = dwe_q;
        di_d    = di_q;
        drdy_d  = 1'b0;
        do_d    = do_q;
        cfg0_d  = cfg0_q;
        cfg1_d  = cfg1_q;
        cfg2_d  = cfg2_q;
        // Any strobe outside D_IDLE (the response cycle included) is dropped.
        err_d   = err_q | (i_den & (state_q != D_IDLE));
        res6_d  = w_wr_aux6 ? {i_aux6_val, 4'b0000} : res6_q;
        res7_d  = w_wr_aux7 ? {i_aux7_val, 4'b0000} : res7_q;

        case (state_q)
            D_IDLE: begin
                if (i_den) begin
                    addr_d = i_daddr;
                    dwe_d  = i_dwe;
                    di_d   = i_di;
                    if (DRDY_LATENCY == 1) begin
                        state_d = D_RESP;
                    end else begin
                        state_d = D_WAIT;
                        lat_d   = LW'(DRDY_LATENCY - 1);
                    end
                end
            end
            D_WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    state_d = D_RESP;
                end
            end
            D_RESP: begin
                drdy_d  = 1'b1;
                state_d = D_IDLE;
                if (!dwe_q) begin
                    do_d = w_rd_data;
                end else begin
                    case (addr_q)
                        ADDR_CFG0: cfg0_d = di_q;
                        ADDR_CFG1: cfg1_d = di_q;
                        ADDR_CFG2: cfg2_d = di_q;
                        default:   ;
                    endcase
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= D_IDLE;
            lat_q   <= '0;
            addr_q  <= 7'd0;
            dwe_q   <= 1'b0;
            di_q    <= 16'd0;
            drdy_q  <= 1'b0;
            do_q    <= 16'd0;
            err_q   <= 1'b0;
            res6_q  <= 16'd0;
            res7_q  <= 16'd0;
            cfg0_q  <= 16'd0;
            cfg1_q  <= 16'd0;
            cfg2_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            dwe_q   <= dwe_d;
            di_q    <= di_d;
            drdy_q  <= drdy_d;
            do_q    <= do_d;
            err_q   <= err_d;
            res6_q  <= res6_d;
            res7_q  <= res7_d;
            cfg0_q  <= cfg0_d;
            cfg1_q  <= cfg1_d;
            cfg2_q  <= cfg2_d;
        end
    end

    assign o_drdy = drdy_q;
    assign o_do   = do_q;
    assign o_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_xadc_drp_responder
// Brief    : Self-checking bench with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_drp_responder;

    localparam int CONV = 26;
    localparam int LAT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_den = 1'b0, i_dwe = 1'b0;
    logic [6:0]  i_daddr = 7'd0;
    logic [15:0] i_di = 16'd0;
    logic [11:0] i_aux6_val = 12'hFFF, i_aux7_val = 12'h100;
    logic        o_drdy, o_eoc, o_eos, o_busy, o_err;
    logic [15:0] o_do;
    logic [4:0]  o_channel;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xadc_drp_responder #(.CONV_CYCLES(CONV), .DRDY_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_den(i_den), .i_dwe(i_dwe),
        .i_daddr(i_daddr), .i_di(i_di), .o_drdy(o_drdy), .o_do(o_do),
        .o_eoc(o_eoc), .o_eos(o_eos), .o_channel(o_channel), .o_busy(o_busy),
        .o_err(o_err), .i_aux6_val(i_aux6_val), .i_aux7_val(i_aux7_val)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts clock edges since reset release.
    int          k = 0;
    logic [15:0] m_res[2];
    logic [15:0] m_cfg[3];
    bit          pend = 0;
    int          resp_k = 0;
    logic [6:0]  m_addr;
    logic        m_we;
    logic [15:0] m_di;
    logic        e_drdy = 0, e_eoc = 0, e_eos = 0, e_busy = 0, e_err = 0;
    logic [15:0] e_do = 0;
    logic [4:0]  e_ch = 0;

    function automatic logic [15:0] m_read(input logic [6:0] a);
        if (a == 7'h16) return m_res[0];
        if (a == 7'h17) return m_res[1];
        if (a >= 7'h40 && a <= 7'h42) return m_cfg[a - 7'h40];
        return 16'h0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; pend = 0;
            m_res[0] = 0; m_res[1] = 0;
            m_cfg[0] = 0; m_cfg[1] = 0; m_cfg[2] = 0;
            e_drdy = 0; e_eoc = 0; e_eos = 0; e_busy = 0; e_err = 0; e_do = 0; e_ch = 0;
        end else begin
            bit was_pend;
            bit accept;
            int n;
            k++;
            was_pend = pend;
            accept = i_den && !was_pend;
            if (i_den && was_pend) e_err = 1;
            e_drdy = 0;
            if (was_pend && k == resp_k) begin
                e_drdy = 1;
                pend = 0;
                if (!m_we) e_do = m_read(m_addr);
                else if (m_addr >= 7'h40 && m_addr <= 7'h42) m_cfg[m_addr - 7'h40] = m_di;
            end
            if (accept) begin
                pend = 1; resp_k = k + LAT;
                m_addr = i_daddr; m_we = i_dwe; m_di = i_di;
            end
            e_eoc = (k % CONV == 0);
            e_eos = 0;
            if (e_eoc) begin
                n = k / CONV;
                if (n % 2 == 1) begin
                    e_ch = 5'd22; m_res[0] = {i_aux6_val, 4'b0000};
                end else begin
                    e_ch = 5'd23; e_eos = 1; m_res[1] = {i_aux7_val, 4'b0000};
                end
            end
            e_busy = !e_eoc;
        end
    end

    always @(posedge clk) begin
        #1;
        check("drdy", o_drdy, e_drdy);
        check("do", o_do, e_do);
        check("eoc", o_eoc, e_eoc);
        check("eos", o_eos, e_eos);
        check("channel", o_channel, e_ch);
        check("busy", o_busy, e_busy);
        check("err", o_err, e_err);
    end

    // Issue one request at a negedge; lat = edges from acceptance to DRDY.
    task automatic req(input logic [6:0] a, input logic we, input logic [15:0] d,
                       output int lat, output logic [15:0] rd);
        i_den = 1; i_dwe = we; i_daddr = a; i_di = d;
        lat = -1; rd = 16'hxxxx;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            i_den = 0;
            if (o_drdy) begin
                lat = i; rd = o_do;
                break;
            end
        end
        if (lat < 0) check("drdy_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] rd;
        int drdy_n, first_i, second_i, waited, nodrdy;

        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_drdy", o_drdy, 0);
        check("rst_do", o_do, 0);
        check("rst_eoc", o_eoc, 0);
        check("rst_ch", o_channel, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        rst_n = 1;
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            if (n == 25) begin
                check("eoc25", o_eoc, 0);
                check("busy25", o_busy, 1);
            end
            if (n == 26) begin
                check("eoc26", o_eoc, 1);
                check("ch26", o_channel, 22);
                check("eos26", o_eos, 0);
                check("busy26", o_busy, 0);
            end
            if (n == 52) begin
                check("eoc52", o_eoc, 1);
                check("eos52", o_eos, 1);
                check("ch52", o_channel, 23);
                check("busy52", o_busy, 0);
            end
        end

        req(7'h16, 0, 0, lat, rd);
        check("lat_rd16", lat, 4);
        check("rd16", rd, 16'hFFF0);
        @(negedge clk);
        check("do_hold", o_do, 16'hFFF0);

        req(7'h41, 1, 16'hA5A5, lat, rd);
        check("lat_wr41", lat, 4);
        check("wr_do_unch", rd, 16'hFFF0);
        req(7'h41, 0, 0, lat, rd);
        check("rd41", rd, 16'hA5A5);
        req(7'h16, 1, 16'h1234, lat, rd);
        check("lat_wr16", lat, 4);
        req(7'h16, 0, 0, lat, rd);
        check("rd16_ro", rd, 16'hFFF0);
        req(7'h55, 0, 0, lat, rd);
        check("rd55", rd, 16'h0000);
        check("err_clean", o_err, 0);

        drdy_n = 0; first_i = -1; second_i = -1;
        for (int i = 0; i < 12; i++) begin
            i_den = (i == 0 || i == 2 || i == 5);
            i_dwe = 0; i_daddr = 7'h40;
            @(negedge clk);
            if (o_drdy) begin
                drdy_n++;
                if (first_i < 0) first_i = i; else second_i = i;
            end
        end
        i_den = 0;
        check("coll_ndrdy", drdy_n, 2);
        check("coll_first", first_i, 4);
        check("coll_second", second_i, 9);
        check("coll_err", o_err, 1);

        waited = 0;
        while ((k % 52) != 47 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("align_timeout", (waited < 200), 1);
        i_aux7_val = 12'h200;
        req(7'h17, 0, 0, lat, rd);
        check("coinc_eoc", o_eoc, 1);
        check("coinc_eos", o_eos, 1);
        check("rd17_old", rd, 16'h1000);
        req(7'h17, 0, 0, lat, rd);
        check("rd17_new", rd, 16'h2000);

        i_den = 1; i_dwe = 0; i_daddr = 7'h16;
        @(negedge clk);
        i_den = 0;
        @(negedge clk);
        rst_n = 0;
        nodrdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_drdy) nodrdy++;
        end
        check("mrst_do", o_do, 0);
        check("mrst_err", o_err, 0);
        check("mrst_ch", o_channel, 0);
        rst_n = 1;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (o_drdy) nodrdy++;
            if (n == 25) check("mrst_eoc25", o_eoc, 0);
            if (n == 26) check("mrst_eoc26", o_eoc, 1);
        end
        check("mrst_nodrdy", nodrdy, 0);

        for (int c = 0; c < 400; c++) begin
            int sel;
            i_den = ($urandom_range(3) == 0);
            i_dwe = $urandom_range(1);
            sel = $urandom_range(5);
            case (sel)
                0: i_daddr = 7'h16;
                1: i_daddr = 7'h17;
                2: i_daddr = 7'h40;
                3: i_daddr = 7'h41;
                4: i_daddr = 7'h42;
                default: i_daddr = 7'($urandom);
            endcase
            i_di = 16'($urandom);
            if ($urandom_range(15) == 0) i_aux6_val = 12'($urandom);
            if ($urandom_range(15) == 0) i_aux7_val = 12'($urandom);
            @(negedge clk);
        end
        i_den = 0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
